// File: rtl/ntt_addr_gen_pkg.sv
// Shared NTT constants, FSM encoding and the delay-line entry layout
// used by the address generator and its sub-blocks.
package ntt_addr_gen_pkg;

    localparam int LANES      = 4;
    localparam int BANK_DEPTH = 128;
    localparam int ADDR_W     = $clog2(BANK_DEPTH);
    localparam int BANK_W     = $clog2(LANES);
    localparam int IDX_W      = ADDR_W + BANK_W;
    localparam int DLY_R2     = 8;
    localparam int DLY_R4     = 14;
    localparam int LINE_DEPTH = DLY_R4 - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                          valid;
        logic                          intt;
        logic [LANES-1:0][ADDR_W-1:0]  addr;
        logic [LANES-1:0][BANK_W-1:0]  bank;
    } line_t;

    localparam int LINE_W = $bits(line_t);

    // Sum of the base-4 digits of a 9-bit index; 2-bit adds wrap to mod 4.
    function automatic logic [BANK_W-1:0] digit_sum(input logic [IDX_W-1:0] n);
        return n[1:0] + n[3:2] + n[5:4] + n[7:6] + {1'b0, n[8]};
    endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// Maps one 9-bit coefficient index to its memory bank and bank-local address.
module ntt_bank_map
    import ntt_addr_gen_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] addr
);

    assign bank = digit_sum(idx);
    assign addr = idx[IDX_W-1:2];

endmodule

// File: rtl/ntt_shifter.sv
// Generic shift register exposing every stage; shifts on each clock.
module ntt_shifter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps <= '0;
        end else begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/ntt_addr_gen.sv
// NTT/INTT butterfly address generator: four lanes of (bank, address) for the
// read side and a mode-dependent delayed copy for the write-back side.
module ntt_addr_gen
    import ntt_addr_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sel,
    input  logic       sel_ntt,
    input  logic [6:0] i,
    input  logic [6:0] k,
    input  logic [6:0] j,
    input  logic [2:0] p,
    output logic [6:0] rd_addr0,
    output logic [6:0] rd_addr1,
    output logic [6:0] rd_addr2,
    output logic [6:0] rd_addr3,
    output logic [1:0] rd_bank0,
    output logic [1:0] rd_bank1,
    output logic [1:0] rd_bank2,
    output logic [1:0] rd_bank3,
    output logic       rd_valid,
    output logic [6:0] wr_addr0,
    output logic [6:0] wr_addr1,
    output logic [6:0] wr_addr2,
    output logic [6:0] wr_addr3,
    output logic [1:0] wr_bank0,
    output logic [1:0] wr_bank1,
    output logic [1:0] wr_bank2,
    output logic [1:0] wr_bank3,
    output logic       wr_valid,
    output logic       wr_intt,
    output logic       drain_done,
    output logic       conflict_err,
    output logic [1:0] dbg_state
);

    state_t                        state_q, state_d;
    logic                          mode_q;
    logic [3:0]                    sh_lo, sh_hi;
    logic [IDX_W-1:0]              base;
    logic [LANES-1:0][IDX_W-1:0]   idx;
    logic [LANES-1:0][BANK_W-1:0]  map_bank;
    logic [LANES-1:0][ADDR_W-1:0]  map_addr;
    logic [LANES-1:0][BANK_W-1:0]  rd_bank_q;
    logic [LANES-1:0][ADDR_W-1:0]  rd_addr_q;
    logic                          rd_valid_q, rd_intt_q;
    logic                          dup, line_busy;
    line_t                         rd_entry, wr_entry;
    logic [LINE_DEPTH-1:0][LINE_W-1:0] line_taps;
    logic [LINE_W-1:0]             wr_bits;

    // Lane indices follow the per-tuple sel; only the write tap is mode-latched.
    always_comb begin
        sh_lo = {p, 1'b0};
        sh_hi = sh_lo + 4'd2;
        base  = ({2'b00, k} << sh_hi) + {2'b00, j};
        for (int m = 0; m < LANES; m++) begin
            if (sel) idx[m] = base + ({7'd0, 2'(m)} << sh_lo);
            else     idx[m] = {2'(m), i};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_map
        ntt_bank_map u_map (
            .idx  (idx[g]),
            .bank (map_bank[g]),
            .addr (map_addr[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_intt_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_bank_q  <= '0;
        end else begin
            rd_valid_q <= en;
            if (en) begin
                rd_addr_q <= map_addr;
                rd_bank_q <= map_bank;
                rd_intt_q <= sel_ntt;
            end
        end
    end

    assign rd_entry = '{valid: rd_valid_q, intt: rd_intt_q, addr: rd_addr_q, bank: rd_bank_q};

    ntt_shifter #(.WIDTH(LINE_W), .DEPTH(LINE_DEPTH)) u_line (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_entry),
        .taps (line_taps)
    );

    assign wr_bits  = mode_q ? line_taps[DLY_R4-2] : line_taps[DLY_R2-2];
    assign wr_entry = line_t'(wr_bits);

    always_comb begin
        line_busy = rd_valid_q;
        for (int d = 0; d < LINE_DEPTH; d++) begin
            line_busy = line_busy | line_taps[d][LINE_W-1];
        end
        dup = 1'b0;
        for (int a = 0; a < LANES; a++) begin
            for (int b = a + 1; b < LANES; b++) begin
                if (rd_bank_q[a] == rd_bank_q[b]) dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            conflict_err <= conflict_err | (rd_valid_q & dup);
            if (state_q == ST_IDLE && en) mode_q <= sel;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (!line_busy) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign dbg_state = state_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr0  = rd_addr_q[0];
    assign rd_addr1  = rd_addr_q[1];
    assign rd_addr2  = rd_addr_q[2];
    assign rd_addr3  = rd_addr_q[3];
    assign rd_bank0  = rd_bank_q[0];
    assign rd_bank1  = rd_bank_q[1];
    assign rd_bank2  = rd_bank_q[2];
    assign rd_bank3  = rd_bank_q[3];
    assign wr_valid  = wr_entry.valid;
    assign wr_intt   = wr_entry.intt;
    assign wr_addr0  = wr_entry.addr[0];
    assign wr_addr1  = wr_entry.addr[1];
    assign wr_addr2  = wr_entry.addr[2];
    assign wr_addr3  = wr_entry.addr[3];
    assign wr_bank0  = wr_entry.bank[0];
    assign wr_bank1  = wr_entry.bank[1];
    assign wr_bank2  = wr_entry.bank[2];
    assign wr_bank3  = wr_entry.bank[3];

endmodule

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserted at 0, deasserted at 1.
REQ-003 en  input  1  index tuple valid this cycle; driven by the NTT control FSM.
REQ-004 sel  input  1  0 = radix-2 stage, 1 = radix-4 stage.
REQ-005 sel_ntt  input  1  0 = NTT, 1 = INTT; passed through with the write-side timing.
REQ-006 i  input  7  radix-2 butterfly-pair index, 0..127.
REQ-007 k, j  input  7 each  radix-4 group index and position index.
REQ-008 p  input  3  radix-4 stage number, 0..3.
REQ-009 rd_addr0..3  output  7 each  bank-local read address of lane m.
REQ-010 rd_bank0..3  output  2 each  bank holding the coefficient of lane m.
REQ-011 rd_valid  output  1  rd_* outputs valid.
REQ-012 wr_addr0..3, wr_bank0..3  output  7/2 each  write-back address and bank per lane.
REQ-013 wr_valid, wr_intt  output  1 each  wr_* valid; delayed sel_ntt.
REQ-014 drain_done  output  1  one-cycle pulse when the write pipeline empties after a run.
REQ-015 conflict_err  output  1  sticky flag: two lanes mapped to one bank.

Function
REQ-016 Radix-2 lane indices n0..n3 SHALL be i, i+128, i+256, i+384 (9-bit).
REQ-017 Radix-4 lane indices SHALL be base + m*4^p, where base = k*4^(p+1) + j and m = 0..3; all arithmetic is 9-bit with no overflow for legal inputs.
REQ-018 Treat n as base-4 digits d0..d3 (bits 7:0) plus d4 = bit 8; bank = (d0+d1+d2+d3+d4) mod 4, address = n[8:2].
REQ-019 rd_* SHALL be registered: en sampled high at edge t gives rd_valid=1 and addresses at t+1.
REQ-020 wr_* SHALL equal rd_* delayed by a valid-tagged delay line: 7 further cycles when sel=0 (total 8), 13 further cycles when sel=1 (total 14).
REQ-021 The tap is chosen by a mode latch captured on the IDLE->RUN transition and held until IDLE; sel changes mid-run are ignored.
REQ-022 FSM states: IDLE, RUN, DRAIN.
REQ-023 Transitions: IDLE->RUN on en=1; RUN->DRAIN on en=0; DRAIN->RUN on en=1; DRAIN->IDLE when no valid entry remains in the delay line, with drain_done=1 for exactly that cycle.
REQ-024 A bubble (en=0 for one cycle) inside RUN SHALL propagate as rd_valid=0 / wr_valid=0 at the matching latencies; address outputs keep their last values.
REQ-025 conflict_err SHALL be set when rd_valid=1 and any two rd_bank values are equal, and cleared only by reset.
REQ-026 wr_intt SHALL follow sel_ntt with the same latency as wr_valid.

Reset
REQ-027 On rst=0, all outputs and delay-line entries SHALL clear to 0 and the FSM SHALL enter IDLE, immediately and independent of clk, including mid-run; no drain_done pulse is produced.

Structure
REQ-028 State encodings, delay constants 8/14, lane count 4 and bank depth 128 SHALL live in the shared NTT package.
REQ-029 Index-to-(bank, address) mapping SHALL be one sub-module, ntt_bank_map, instantiated four times.
REQ-030 The delay line SHALL reuse the codebase's existing shifter block.

Verification
REQ-031 sel=1, p=0, k=0, j=0, en pulse -> next cycle banks 0,1,2,3, addr 0,0,0,0, rd_valid=1.
REQ-032 sel=1, p=3, k=0, j=5 -> banks 2,3,0,1, addr 1,17,33,49; same values on wr_* 14 cycles after en.
REQ-033 sel=0, i=1 -> banks 1,3,2,0, addr 0,32,64,96; wr_valid rises 8 cycles after en.
REQ-034 Full sweeps (radix-2: i=0..127; radix-4: all legal p,k,j) -> conflict_err stays 0, and every (bank, addr) pair appears exactly once per stage.
REQ-035 Drop rst to 0 during DRAIN -> outputs 0, FSM IDLE, no drain_done; after release, a normal run drains with exactly one drain_done pulse.
REQ-036 Toggle sel mid-run -> wr latency unchanged until the FSM returns to IDLE.
